eth_tx_frame_buffer: RTL and testbench

Store-and-forward frame FIFO placed directly upstream of the 1G MAC TX AXI-Stream input, in the gtx_clk domain. It accepts byte-wide frames from the traffic source and releases a frame only once the whole frame is stored. The MAC therefore never sees tvalid drop mid-frame, so tx_error (underflow) cannot occur. Errored, oversize or overflowing frames are discarded whole and counted.

---
 rtl/eth_tx_pkg.sv | 14 +
 rtl/eth_tx_buffer_ram.sv | 31 +++
 rtl/eth_tx_frame_buffer.sv | 184 ++++++++++++++++++
 tb/tb_eth_tx_frame_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared constants and write-side state encoding for the gtx_clk TX frame buffer.
package eth_tx_pkg;

  localparam int ADDR_W_DEFAULT    = 11;
  localparam int DEPTH             = 2 ** ADDR_W_DEFAULT;
  localparam int MAX_FRAME_DEFAULT = 1522;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/eth_tx_buffer_ram.sv
// Simple dual-port RAM, one write port and one registered read port (BRAM style).
module eth_tx_buffer_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value when no read is issued
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/eth_tx_frame_buffer.sv
// Store-and-forward TX frame FIFO in front of the 1G MAC: a frame is released only
// once fully stored; bad, oversize or overflowing frames are discarded and counted.
module eth_tx_frame_buffer
  import eth_tx_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int MAX_FRAME = MAX_FRAME_DEFAULT
) (
  input  logic            gtx_clk,
  input  logic            gtx_rst,
  input  logic [7:0]      s_axis_tdata,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  input  logic            s_axis_tuser,
  output logic            s_axis_tready,
  output logic [7:0]      m_axis_tdata,
  output logic            m_axis_tvalid,
  output logic            m_axis_tlast,
  output logic            m_axis_tuser,
  input  logic            m_axis_tready,
  output logic [31:0]     frames_sent,
  output logic [31:0]     frames_dropped,
  output logic [ADDR_W:0] occupancy
);

  localparam int               PTR_W      = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] BUF_FULL   = PTR_W'(2 ** ADDR_W);
  localparam logic [PTR_W-1:0] LAST_LEGAL = PTR_W'(MAX_FRAME - 1);

  wr_state_t        state_r, state_nxt_s;
  logic [PTR_W-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [PTR_W-1:0] wr_commit_r, wr_commit_nxt_s;
  logic [PTR_W-1:0] byte_cnt_r, byte_cnt_nxt_s;
  logic [PTR_W-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic [PTR_W-1:0] rd_addr_r;
  logic [PTR_W-1:0] occ_r;
  logic             beat_s, full_s, trig_s, wr_en_s, drop_s;
  logic             s_ready_r;
  logic             rd_issue_s, pend_r, out_free_s, consume_s;
  logic             out_valid_r, out_last_r;
  logic [7:0]       out_data_r;
  logic [8:0]       ram_rd_data_s;
  logic [31:0]      sent_r, dropped_r;

  assign beat_s = s_axis_tvalid & s_ready_r;
  // Full is judged against the consumed pointer, so prefetched bytes still count as stored
  assign full_s = ((wr_ptr_r - rd_ptr_r) == BUF_FULL);
  // A 1522nd byte without tlast means the frame is already oversize
  assign trig_s = full_s
                | ((byte_cnt_r == LAST_LEGAL) & ~s_axis_tlast)
                | (s_axis_tlast & s_axis_tuser);

  // Write FSM next-state and pointer updates
  always_comb begin
    state_nxt_s     = state_r;
    wr_ptr_nxt_s    = wr_ptr_r;
    wr_commit_nxt_s = wr_commit_r;
    byte_cnt_nxt_s  = byte_cnt_r;
    wr_en_s         = 1'b0;
    drop_s          = 1'b0;
    case (state_r)
      ST_IDLE, ST_WRITE: begin
        if (beat_s) begin
          if (trig_s) begin
            drop_s         = 1'b1;
            wr_ptr_nxt_s   = wr_commit_r;
            byte_cnt_nxt_s = '0;
            if (s_axis_tlast) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_DROP;
            end
          end else begin
            wr_en_s      = 1'b1;
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            if (s_axis_tlast) begin
              wr_commit_nxt_s = wr_ptr_r + PTR_ONE;
              byte_cnt_nxt_s  = '0;
              state_nxt_s     = ST_IDLE;
            end else begin
              byte_cnt_nxt_s = byte_cnt_r + PTR_ONE;
              state_nxt_s    = ST_WRITE;
            end
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DROP: begin
        if (beat_s && s_axis_tlast) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Write-side state, pointers and drop counter
  always_ff @(posedge gtx_clk or posedge gtx_rst) begin
    if (gtx_rst) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= '0;
      wr_commit_r <= '0;
      byte_cnt_r  <= '0;
      dropped_r   <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      wr_commit_r <= wr_commit_nxt_s;
      byte_cnt_r  <= byte_cnt_nxt_s;
      if (drop_s) begin
        dropped_r <= dropped_r + 32'd1;
      end
    end
  end

  assign out_free_s   = ~out_valid_r | m_axis_tready;
  assign consume_s    = out_valid_r & m_axis_tready;
  assign rd_issue_s   = (rd_addr_r != wr_commit_r) & (~pend_r | out_free_s);
  assign rd_ptr_nxt_s = rd_ptr_r + (consume_s ? PTR_ONE : '0);

  // Read pipeline: fetch address, RAM-output slot, output register, consumed pointer
  always_ff @(posedge gtx_clk or posedge gtx_rst) begin
    if (gtx_rst) begin
      s_ready_r   <= 1'b0;
      rd_addr_r   <= '0;
      rd_ptr_r    <= '0;
      pend_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
      out_last_r  <= 1'b0;
      sent_r      <= 32'd0;
      occ_r       <= '0;
    end else begin
      s_ready_r <= 1'b1;
      rd_ptr_r  <= rd_ptr_nxt_s;
      occ_r     <= wr_commit_nxt_s - rd_ptr_nxt_s;
      if (rd_issue_s) begin
        rd_addr_r <= rd_addr_r + PTR_ONE;
        pend_r    <= 1'b1;
      end else if (pend_r && out_free_s) begin
        pend_r <= 1'b0;
      end
      if (pend_r && out_free_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= ram_rd_data_s[7:0];
        out_last_r  <= ram_rd_data_s[8];
      end else if (consume_s) begin
        out_valid_r <= 1'b0;
      end
      if (consume_s && out_last_r) begin
        sent_r <= sent_r + 32'd1;
      end
    end
  end

  eth_tx_buffer_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (9)
  ) u_ram (
    .clk     (gtx_clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tdata}),
    .rd_en   (rd_issue_s),
    .rd_addr (rd_addr_r[ADDR_W-1:0]),
    .rd_data (ram_rd_data_s)
  );

  assign s_axis_tready  = s_ready_r;
  assign m_axis_tdata   = out_data_r;
  assign m_axis_tvalid  = out_valid_r;
  assign m_axis_tlast   = out_last_r;
  assign m_axis_tuser   = 1'b0;
  assign frames_sent    = sent_r;
  assign frames_dropped = dropped_r;
  assign occupancy      = occ_r;

endmodule

// File: tb/tb_eth_tx_frame_buffer.sv
// Self-checking bench for eth_tx_frame_buffer: frame table, hand-written corner
// sequences and randomized frames against a frame-level scoreboard model.
module tb_eth_tx_frame_buffer;

  localparam int ADDR_W    = 11;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int MAX_FRAME = 1522;

  logic            gtx_clk = 1'b0;
  logic            gtx_rst = 1'b1;
  logic [7:0]      s_axis_tdata = 8'd0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tlast = 1'b0;
  logic            s_axis_tuser = 1'b0;
  logic            s_axis_tready;
  logic [7:0]      m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tuser;
  logic            m_axis_tready = 1'b0;
  logic [31:0]     frames_sent;
  logic [31:0]     frames_dropped;
  logic [ADDR_W:0] occupancy;

  int total = 0;
  int bad = 0;
  int rmode = 1;            // 0: MAC stalled, 1: MAC always ready, 2: random ready
  int exp_sent = 0;
  int exp_dropped = 0;
  logic [8:0] exp_q [$];    // expected output beats {tlast, tdata}

  typedef struct {
    int len;
    bit bad_f;
    bit accept;
  } vec_t;

  eth_tx_frame_buffer #(.ADDR_W(ADDR_W), .MAX_FRAME(MAX_FRAME)) dut (
    .gtx_clk        (gtx_clk),
    .gtx_rst        (gtx_rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tready  (m_axis_tready),
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped),
    .occupancy      (occupancy)
  );

  initial forever #4 gtx_clk = ~gtx_clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level reference: a frame is kept only if it is good, not oversize, and fits.
  function automatic bit model_accept(input int len, input bit bad_f);
    return !bad_f && (len <= MAX_FRAME) && (exp_q.size() + len <= DEPTH);
  endfunction

  task automatic send_frame(input int len, input bit bad_f, input bit accept, input int max_gap);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = bad_f && (i == len - 1);
      if (accept) exp_q.push_back({s_axis_tlast, d});
      @(posedge gtx_clk); #1;
      if (max_gap > 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge gtx_clk); #1;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tdata  = 8'd0;
    if (accept) exp_sent++;
    else exp_dropped++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 6000) begin
      @(negedge gtx_clk);
      n++;
    end
    total++;
    if (n >= 6000) begin
      bad++;
      $display("FAIL %s_drain: %0d beats still expected after %0d cycles", name, exp_q.size(), n);
    end
    @(negedge gtx_clk);
  endtask

  task automatic check_counts(input string name);
    check({name, "_sent"}, frames_sent, exp_sent);
    check({name, "_dropped"}, frames_dropped, exp_dropped);
    check({name, "_occ"}, occupancy, 0);
  endtask

  // MAC-side ready driver
  initial forever begin
    @(posedge gtx_clk); #1;
    if (rmode == 2) m_axis_tready = 1'($urandom_range(0, 1));
    else m_axis_tready = (rmode == 1);
  end

  // Output monitor: scoreboard compare, hold-under-stall and no-gap checks
  initial begin
    logic       prev_stall;
    logic [8:0] prev_out;
    logic [8:0] e;
    bit         in_frame;
    prev_stall = 1'b0;
    prev_out   = 9'd0;
    in_frame   = 1'b0;
    forever begin
      @(negedge gtx_clk);
      if (gtx_rst) begin
        prev_stall = 1'b0;
        in_frame   = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", m_axis_tvalid, 1);
          check("hold_data", {m_axis_tlast, m_axis_tdata}, prev_out);
        end else if (in_frame) begin
          check("no_gap", m_axis_tvalid, 1);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %h expected no output", {m_axis_tlast, m_axis_tdata});
          end else begin
            e = exp_q.pop_front();
            check("beat", {m_axis_tlast, m_axis_tdata}, e);
          end
          in_frame = !m_axis_tlast;
        end
        check("tuser", m_axis_tuser, 0);
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [9];
    int   len;
    bit   bf;
    bit   acc;
    int   sent_before;

    vecs[0] = '{64, 1'b0, 1'b1};
    vecs[1] = '{100, 1'b1, 1'b0};
    vecs[2] = '{60, 1'b0, 1'b1};
    vecs[3] = '{1, 1'b0, 1'b1};
    vecs[4] = '{1522, 1'b0, 1'b1};
    vecs[5] = '{1600, 1'b0, 1'b0};
    vecs[6] = '{2, 1'b1, 1'b0};
    vecs[7] = '{1, 1'b1, 1'b0};
    vecs[8] = '{300, 1'b0, 1'b1};

    // Reset state
    #2;
    check("rst_s_ready", s_axis_tready, 0);
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_m_data", m_axis_tdata, 0);
    check("rst_m_last", m_axis_tlast, 0);
    check("rst_sent", frames_sent, 0);
    check("rst_dropped", frames_dropped, 0);
    check("rst_occ", occupancy, 0);
    repeat (3) @(negedge gtx_clk);
    gtx_rst = 1'b0;
    repeat (2) @(negedge gtx_clk);
    check("ready_after_rst", s_axis_tready, 1);

    // 64-byte frame: tvalid rises after the second edge following the tlast edge
    rmode = 1;
    send_frame(64, 1'b0, 1'b1, 0);
    @(negedge gtx_clk);
    check("lat_e0", m_axis_tvalid, 0);
    @(negedge gtx_clk);
    check("lat_e1", m_axis_tvalid, 0);
    @(negedge gtx_clk);
    check("lat_e2", m_axis_tvalid, 1);
    wait_drain("lat");
    check_counts("lat");

    // Table of frames with known fate, MAC always ready
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].len, vecs[i].bad_f, vecs[i].accept, 0);
      wait_drain($sformatf("vec%0d", i));
      check_counts($sformatf("vec%0d", i));
    end

    // Overflow: MAC stalled while five 500-byte frames arrive
    rmode = 0;
    repeat (2) @(negedge gtx_clk);
    sent_before = exp_sent;
    for (int i = 0; i < 5; i++) begin
      acc = model_accept(500, 1'b0);
      send_frame(500, 1'b0, acc, 0);
    end
    @(negedge gtx_clk);
    check("ovf_occ", occupancy, exp_q.size());
    check("ovf_dropped", frames_dropped, exp_dropped);
    check("ovf_sent_stalled", frames_sent, sent_before);
    rmode = 1;
    wait_drain("ovf");
    check_counts("ovf");

    // Random frames with random MAC ready and input gaps
    rmode = 2;
    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(1, 300);
      bf  = ($urandom_range(0, 4) == 0);
      acc = model_accept(len, bf);
      send_frame(len, bf, acc, 2);
    end
    wait_drain("rand");
    check_counts("rand");
    send_frame(MAX_FRAME, 1'b0, model_accept(MAX_FRAME, 1'b0), 0);
    wait_drain("max_toggle");
    check_counts("max_toggle");

    // Reset while a frame is streaming out
    rmode = 1;
    send_frame(200, 1'b0, 1'b1, 0);
    repeat (20) @(negedge gtx_clk);
    #1;
    gtx_rst = 1'b1;
    exp_q.delete();
    exp_sent = 0;
    exp_dropped = 0;
    #1;
    check("mid_rst_valid", m_axis_tvalid, 0);
    check("mid_rst_data", m_axis_tdata, 0);
    check("mid_rst_last", m_axis_tlast, 0);
    check("mid_rst_s_ready", s_axis_tready, 0);
    check("mid_rst_sent", frames_sent, 0);
    check("mid_rst_occ", occupancy, 0);
    repeat (3) @(negedge gtx_clk);
    gtx_rst = 1'b0;
    repeat (3) @(negedge gtx_clk);
    check_counts("post_rst");
    check("post_rst_valid", m_axis_tvalid, 0);
    check("post_rst_ready", s_axis_tready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
